// File: rtl/calc_pkg.sv
// Shared opcode encodings and FSM state type for the parametrised calculator core.
package calc_pkg;

   localparam logic [1:0] OP_ROT = 2'b00;
   localparam logic [1:0] OP_ADD = 2'b01;
   localparam logic [1:0] OP_SUB = 2'b10;
   localparam logic [1:0] OP_MUL = 2'b11;

   typedef enum logic [2:0] {
      ST_INIT,
      ST_IDLE,
      ST_EXEC,
      ST_MUL,
      ST_DONE
   } calc_state_t;

endpackage

// File: rtl/calc_mul_seq.sv
// Iterative shift-add multiplier: loads on i_start, runs WIDTH iterations,
// then pulses o_done for one cycle with the full 2*WIDTH product on o_prod.
module calc_mul_seq #(
   parameter int WIDTH = 8
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_start,
   input  logic [WIDTH-1:0]   i_a,
   input  logic [WIDTH-1:0]   i_b,
   output logic               o_done,
   output logic [2*WIDTH-1:0] o_prod
);

   localparam int CW = $clog2(WIDTH);

   logic [2*WIDTH-1:0] r_mcand;
   logic [2*WIDTH-1:0] r_acc;
   logic [WIDTH-1:0]   r_mplier;
   logic [CW-1:0]      r_cnt;
   logic               r_run;
   logic               r_done;

   // One multiplier bit is consumed per cycle; done fires on the last iteration edge.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_mcand  <= '0;
         r_acc    <= '0;
         r_mplier <= '0;
         r_cnt    <= '0;
         r_run    <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (i_start) begin
            r_mcand  <= {{WIDTH{1'b0}}, i_a};
            r_mplier <= i_b;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_run    <= 1'b1;
         end else if (r_run) begin
            if (r_mplier[0]) begin
               r_acc <= r_acc + r_mcand;
            end
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + 1'b1;
            if (r_cnt == CW'(WIDTH - 1)) begin
               r_run  <= 1'b0;
               r_done <= 1'b1;
            end
         end
      end
   end

   assign o_done = r_done;
   assign o_prod = r_acc;

endmodule

// File: rtl/calc_core_p.sv
// Parametrised calculator core: handshake-driven rotate/add/sub/mul with an init
// window, wrap or saturate results, and a registered result with a DataReady pulse.
module calc_core_p
   import calc_pkg::*;
#(
   parameter int WIDTH       = 8,
   parameter int INIT_CYCLES = 4,
   parameter int SATURATE    = 0
) (
   input  logic             Clk,
   input  logic             Rst_n,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [1:0]       OpCode,
   input  logic             OpCodeValid,
   output logic [WIDTH-1:0] Z,
   output logic             DataReady,
   output logic             Overflow,
   output logic             Busy,
   output logic             Initializing
);

   localparam int SW  = $clog2(WIDTH);
   localparam int ICW = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
   localparam bit SAT = (SATURATE != 0);

   calc_state_t        r_state;
   calc_state_t        w_next;
   logic [ICW-1:0]     r_initCnt;
   logic [WIDTH-1:0]   r_a;
   logic [WIDTH-1:0]   r_b;
   logic [1:0]         r_op;
   logic [WIDTH-1:0]   r_res;
   logic               r_ovf;
   logic [WIDTH-1:0]   r_z;
   logic               r_ovfOut;
   logic               r_dataReady;
   logic               w_accept;
   logic               w_mulStart;
   logic               w_mulDone;
   logic [2*WIDTH-1:0] w_prod;
   logic [2*WIDTH-1:0] w_rotDbl;
   logic [WIDTH:0]     w_sum;
   logic [WIDTH-1:0]   w_execRes;
   logic               w_execOvf;

   assign w_accept   = OpCodeValid && (r_state == ST_IDLE || r_state == ST_DONE);
   assign w_mulStart = w_accept && (OpCode == OP_MUL);
   assign w_rotDbl   = {r_a, r_a} << r_b[SW-1:0];
   assign w_sum      = {1'b0, r_a} + {1'b0, r_b};

   calc_mul_seq #(.WIDTH(WIDTH)) u_mul (
      .i_clk   (Clk),
      .i_rst_n (Rst_n),
      .i_start (w_mulStart),
      .i_a     (A),
      .i_b     (B),
      .o_done  (w_mulDone),
      .o_prod  (w_prod)
   );

   // Result and flag for whichever operation is finishing; mul uses the default arm.
   always_comb begin
      w_execRes = '0;
      w_execOvf = 1'b0;
      case (r_op)
         OP_ROT: w_execRes = w_rotDbl[2*WIDTH-1:WIDTH];
         OP_ADD: begin
            w_execOvf = w_sum[WIDTH];
            w_execRes = (SAT && w_execOvf) ? '1 : w_sum[WIDTH-1:0];
         end
         OP_SUB: begin
            w_execOvf = (r_a < r_b);
            w_execRes = (SAT && w_execOvf) ? '0 : r_a - r_b;
         end
         default: begin
            w_execOvf = |w_prod[2*WIDTH-1:WIDTH];
            w_execRes = (SAT && w_execOvf) ? '1 : w_prod[WIDTH-1:0];
         end
      endcase
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_INIT: if (r_initCnt == ICW'(INIT_CYCLES - 1)) w_next = ST_IDLE;
         ST_IDLE, ST_DONE: begin
            w_next = ST_IDLE;
            if (OpCodeValid) w_next = (OpCode == OP_MUL) ? ST_MUL : ST_EXEC;
         end
         ST_EXEC: w_next = ST_DONE;
         ST_MUL:  if (w_mulDone) w_next = ST_DONE;
         default: w_next = ST_INIT;
      endcase
   end

   // The result is staged in r_res and only published to Z on leaving DONE,
   // so Z and DataReady always change together.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         r_state     <= ST_INIT;
         r_initCnt   <= '0;
         r_a         <= '0;
         r_b         <= '0;
         r_op        <= OP_ROT;
         r_res       <= '0;
         r_ovf       <= 1'b0;
         r_z         <= '0;
         r_ovfOut    <= 1'b0;
         r_dataReady <= 1'b0;
      end else begin
         r_state <= w_next;
         if (r_state == ST_INIT) r_initCnt <= r_initCnt + 1'b1;
         if (w_accept) begin
            r_a  <= A;
            r_b  <= B;
            r_op <= OpCode;
         end
         if (r_state == ST_EXEC || (r_state == ST_MUL && w_mulDone)) begin
            r_res <= w_execRes;
            r_ovf <= w_execOvf;
         end
         r_dataReady <= (r_state == ST_DONE);
         if (r_state == ST_DONE) begin
            r_z      <= r_res;
            r_ovfOut <= r_ovf;
         end
      end
   end

   assign Z            = r_z;
   assign Overflow     = r_ovfOut;
   assign DataReady    = r_dataReady;
   assign Busy         = (r_state == ST_EXEC) || (r_state == ST_MUL);
   assign Initializing = (r_state == ST_INIT);

endmodule
